digit_scan_ctrl: RTL
====================

# digit_scan_ctrl

Sequential scan controller that drives the enable and 2-bit select inputs of the 2-to-4 active-low decoder stage (G_L, A, B) to time-multiplex four digit/row drivers. It steps through enabled digits at a fixed slot rate and skips masked digits. A blanking interval precedes every drive window, so the decoder select lines never change while the decoder is enabled. It sits directly upstream of the decoder, and its {B,A} also steers the segment-data mux.

## Interface
Parameters:
- DIV, default 8: slot length in CLK cycles. Requires DIV > BLANK.
- BLANK, default 2: G_L-high cycles at the start of each slot. Requires BLANK >= 2.

Ports:
- CLK, input, 1: single clock, rising edge.
- RESET, input, 1: synchronous, active-high reset.
- EN, input, 1: scan enable.
- MASK, input, 4: per-digit enable, 1 = digit participates.
- G_L, output, 1: decoder enable, active-low.
- A, output, 1: select LSB.
- B, output, 1: select MSB.
- WRAP, output, 1: one-cycle pulse when the scan index wraps.
- ACTIVE, output, 1: high whenever the state is not IDLE.

## Operation
- All outputs are registered. Reset values: G_L=1, A=0, B=0, WRAP=0, ACTIVE=0, state=IDLE, sel=0, slot counter=0.
- States:
  - IDLE: G_L=1 and {B,A} holds the last sel.
  - BLNK: G_L=1.
  - DRIVE: G_L=0.
- IDLE to BLNK: when EN=1 and MASK!=0. Target = first set MASK bit searching upward from the current sel, inclusive, cyclically.
- BLNK:
  - First cycle: G_L=1 and {B,A} still shows the old index.
  - {B,A} loads the target at the end of the first BLNK cycle.
  - After BLANK cycles in total, go to DRIVE.
- DRIVE:
  - Lasts DIV-BLANK cycles.
  - Then go to BLNK with target = next set MASK bit strictly after sel, cyclically.
  - If only one bit is set, the target is sel itself; the slot still passes through BLNK.
- WRAP is asserted in the first BLNK cycle of a slot whose target <= previous sel. With a single active digit it pulses every slot.
- {B,A} never changes in a cycle where G_L=0, and never on the same edge that G_L rises.
- EN sampled 0 in any state: IDLE on the next edge, G_L=1, sel held, counter cleared.
- MASK is sampled every cycle:
  - Current digit's bit cleared during BLNK or DRIVE: enter BLNK for the next active digit on the next edge, with the counter restarted.
  - MASK becomes 0: go to IDLE.
  - Newly set bits take effect at the next target selection.
- RESET has priority over EN and MASK in every state.

## Timing
- First G_L low occurs BLANK+1 edges after the edge at which EN=1 (with MASK!=0) is first sampled in IDLE.
- Steady-state slot is exactly DIV cycles: BLANK cycles of G_L=1, then DIV-BLANK cycles of G_L=0.
- With defaults and MASK=1111, the full scan period is 32 cycles and WRAP fires every 32 cycles.
- Abort (EN low, or current digit masked) raises G_L on the very next edge. There is no partial-slot completion.
- Select stability: {B,A} settles at least 1 cycle before G_L falls and is held at least 1 cycle after G_L rises.

## Structure
- Shared package holds:
  - state enum {IDLE, BLNK, DRIVE}, 2-bit encoding;
  - counter width constant derived from DIV.
- Sub-module digit_next_pick: combinational rotate-priority picker.
  - Inputs: MASK, sel, inclusive flag.
  - Outputs: next index, wrap flag, none flag.
  - The FSM instantiates it once.
- The decoder stage is instantiated by the parent, not inside this block.

## Test plan
- RESET=1 for 3 cycles with EN=1, MASK=1111: G_L=1, A=B=0, WRAP=0, ACTIVE=0 throughout. After release, the first G_L low arrives 3 edges later with {B,A}=00.
- EN=1, MASK=1111, defaults:
  - {B,A} sequence is 00,01,10,11,00…
  - Each digit has 6 cycles of G_L=0 and 2 cycles of G_L=1.
  - {B,A} changes only in cycles where G_L was already 1 on the previous cycle.
  - WRAP pulses once per 32 cycles, at the 11→00 transition.
- MASK=0101: sequence is 00,10,00,10; WRAP every 16 cycles. MASK=1000: {B,A}=11 constantly, WRAP every 8 cycles.
- During DRIVE of digit 2 with MASK=1111, change MASK to 1011: G_L=1 on the next edge, then BLNK and DRIVE of digit 3 with a full 6-cycle drive window.
- EN=0 mid-DRIVE at digit 1: next edge gives G_L=1, ACTIVE=0, {B,A}=01 held. EN=1 again: resumes at digit 1 after 2 blank cycles.
- RESET pulse mid-DRIVE at digit 2: next edge gives reset values. EN=1 with MASK=0000: stays IDLE, G_L=1 indefinitely.

Source files
------------

// File: rtl/digit_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// digit_scan_ctrl_pkg
//
// Shared definitions for the digit scan controller:
//   - scan_state_e : FSM state encoding (2 bits)
//   - DEF_DIV      : default slot length in clock cycles
//   - DEF_BLANK    : default blanking length at the start of each slot
//   - cnt_width()  : width of the in-slot cycle counter for a given slot length
// -----------------------------------------------------------------------------
package digit_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // decoder disabled, select holds the last digit
        BLNK  = 2'd1,   // decoder disabled, select moves to the target digit
        DRIVE = 2'd2    // decoder enabled, select frozen
    } scan_state_e;

    localparam int DEF_DIV   = 8;
    localparam int DEF_BLANK = 2;

    // The counter only has to reach DIV-1; keep at least one bit.
    function automatic int cnt_width(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage : digit_scan_ctrl_pkg

// File: rtl/digit_scan_ctrl_next_pick.sv
// -----------------------------------------------------------------------------
// digit_next_pick
//
// Combinational rotate-priority picker over four digit enables. Starting from
// i_sel (inclusive) or from the digit after i_sel (exclusive), it searches
// upward, wrapping 3 -> 0, for the first digit whose mask bit is set.
//
// Ports:
//   i_mask  [3:0]  per-digit enable, 1 = digit participates
//   i_sel   [1:0]  reference index for the search
//   i_incl         1 = i_sel itself is a candidate, 0 = start after i_sel
//   o_idx   [1:0]  chosen digit (i_sel when nothing is set)
//   o_wrap         chosen digit is at or below the reference index
//   o_none         no digit enabled at all
// -----------------------------------------------------------------------------
module digit_next_pick (
    input  logic [3:0] i_mask,
    input  logic [1:0] i_sel,
    input  logic       i_incl,
    output logic [1:0] o_idx,
    output logic       o_wrap,
    output logic       o_none
);

    logic [1:0] w_start;
    logic [1:0] w_cand;
    logic       w_found;

    // NOTE: every variable written here gets a default before any branch, so
    // no path leaves a value held over and no latch is inferred.
    always_comb begin
        w_start = i_incl ? i_sel : i_sel + 2'd1;
        w_cand  = w_start;
        w_found = 1'b0;
        o_idx   = i_sel;
        // Offsets 0..3 from the start point cover all four digits once; the
        // 2-bit sum wraps naturally from 3 back to 0.
        for (int k = 0; k < 4; k++) begin
            w_cand = w_start + 2'(k);
            if (!w_found && i_mask[w_cand]) begin
                o_idx   = w_cand;
                w_found = 1'b1;
            end
        end
        o_none = ~|i_mask;
        o_wrap = !o_none && (o_idx <= i_sel);
    end

endmodule : digit_next_pick

// File: rtl/digit_scan_ctrl.sv
// -----------------------------------------------------------------------------
// digit_scan_ctrl
//
// Scan controller in front of a 2-to-4 active-low decoder. It steps through
// the enabled digits, giving each one a slot of DIV cycles: BLANK cycles with
// the decoder disabled (G_L=1) followed by DIV-BLANK cycles with it enabled.
// The select lines {B,A} only move in the second blanking cycle, so they are
// stable for a full cycle on both sides of every G_L low window.
//
// Parameters:
//   DIV    slot length in CLK cycles (must exceed BLANK)
//   BLANK  blanking cycles at the start of each slot (at least 2)
//
// Ports:
//   CLK     clock, rising edge
//   RESET   synchronous reset, active high, overrides everything
//   EN      scan enable; low forces IDLE on the next edge
//   MASK    per-digit enable, 1 = digit participates
//   G_L     decoder enable, active low
//   A, B    decoder select LSB / MSB
//   WRAP    one-cycle pulse in the first blanking cycle of a slot whose
//           target index is not above the previously selected index
//   ACTIVE  high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module digit_scan_ctrl
    import digit_scan_ctrl_pkg::*;
#(
    parameter int DIV   = DEF_DIV,
    parameter int BLANK = DEF_BLANK
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       EN,
    input  logic [3:0] MASK,
    output logic       G_L,
    output logic       A,
    output logic       B,
    output logic       WRAP,
    output logic       ACTIVE
);

    localparam int CNT_W = cnt_width(DIV);

    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);

    // -------------------------------------------------------------------------
    // State
    //   r_sel : index currently presented on {B,A}
    //   r_tgt : index the current slot belongs to; loaded into r_sel at the
    //           end of the first blanking cycle, equal to r_sel during DRIVE
    //   r_cnt : cycle position within the slot, 0 .. DIV-1
    // -------------------------------------------------------------------------
    scan_state_e      r_state;
    logic [1:0]       r_sel;
    logic [1:0]       r_tgt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_g_l;
    logic             r_wrap;
    logic             r_active;

    // -------------------------------------------------------------------------
    // Next-target selection. From IDLE the search includes the held index so a
    // resumed scan restarts on the same digit; otherwise it starts after the
    // digit of the current slot.
    // -------------------------------------------------------------------------
    logic [1:0] w_pick_sel;
    logic       w_pick_incl;
    logic [1:0] w_pick_idx;
    logic       w_pick_wrap;
    logic       w_pick_none;
    logic       w_cur_masked;

    assign w_pick_incl  = (r_state == IDLE);
    assign w_pick_sel   = w_pick_incl ? r_sel : r_tgt;
    assign w_cur_masked = !MASK[r_tgt];

    digit_next_pick u_next_pick (
        .i_mask (MASK),
        .i_sel  (w_pick_sel),
        .i_incl (w_pick_incl),
        .o_idx  (w_pick_idx),
        .o_wrap (w_pick_wrap),
        .o_none (w_pick_none)
    );

    // -------------------------------------------------------------------------
    // Scan FSM with registered outputs.
    // -------------------------------------------------------------------------
    // NOTE: all state here is assigned with non-blocking assignments, so every
    // branch reads the values from before the edge regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= IDLE;
            r_sel    <= 2'd0;
            r_tgt    <= 2'd0;
            r_cnt    <= CNT_ZERO;
            r_g_l    <= 1'b1;
            r_wrap   <= 1'b0;
            r_active <= 1'b0;
        end else begin
            // WRAP is a single-cycle pulse; only slot starts raise it.
            r_wrap <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_g_l <= 1'b1;
                    r_cnt <= CNT_ZERO;
                    if (EN && !w_pick_none) begin
                        r_state  <= BLNK;
                        r_tgt    <= w_pick_idx;
                        r_wrap   <= w_pick_wrap;
                        r_active <= 1'b1;
                    end
                end

                BLNK, DRIVE: begin
                    if (!EN || w_pick_none) begin
                        // Abort: decoder off at once, select held where it is.
                        r_state  <= IDLE;
                        r_g_l    <= 1'b1;
                        r_cnt    <= CNT_ZERO;
                        r_active <= 1'b0;
                    end else if (w_cur_masked) begin
                        // Current digit withdrawn: restart a full slot on the
                        // next enabled digit.
                        r_state <= BLNK;
                        r_tgt   <= w_pick_idx;
                        r_wrap  <= w_pick_wrap;
                        r_g_l   <= 1'b1;
                        r_cnt   <= CNT_ZERO;
                    end else if (r_state == BLNK) begin
                        // Move the select only after one full disabled cycle.
                        if (r_cnt == CNT_ZERO) begin
                            r_sel <= r_tgt;
                        end
                        if (r_cnt == BLANK_LAST) begin
                            r_state <= DRIVE;
                            r_g_l   <= 1'b0;
                        end
                        r_cnt <= r_cnt + CNT_ONE;
                    end else begin
                        if (r_cnt == DIV_LAST) begin
                            r_state <= BLNK;
                            r_tgt   <= w_pick_idx;
                            r_wrap  <= w_pick_wrap;
                            r_g_l   <= 1'b1;
                            r_cnt   <= CNT_ZERO;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    r_g_l    <= 1'b1;
                    r_cnt    <= CNT_ZERO;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign G_L    = r_g_l;
    assign A      = r_sel[0];
    assign B      = r_sel[1];
    assign WRAP   = r_wrap;
    assign ACTIVE = r_active;

endmodule : digit_scan_ctrl
